// File: rtl/pixcount_pkg.sv
// Shared types and defaults for the windowed non-black pixel counter.
package pixcount_pkg;

    localparam int COORD_W      = 11;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_CNT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_COUNT,
        ST_DONE
    } state_t;

    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive rectangular measurement window.
    typedef struct packed {
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } window_t;

    // Inclusive range test; an inverted range (lo > hi) never matches.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixcount_if.sv
// Video-in, window, control and result-handshake bundle for pixcount_ctrl.
// master: the driver/consumer side; slave: the counter itself.
interface pixcount_if
    import pixcount_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             frame_start;
    logic             pix_valid;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;
    coord_t           win_x0;
    coord_t           win_x1;
    coord_t           win_y0;
    coord_t           win_y1;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             result_ack;
    logic             overflow;

    modport master (
        output start, frame_start, pix_valid, r, g, b,
        output win_x0, win_x1, win_y0, win_y1, result_ack,
        input  busy, result, result_valid, overflow
    );

    modport slave (
        input  start, frame_start, pix_valid, r, g, b,
        input  win_x0, win_x1, win_y0, win_y1, result_ack,
        output busy, result, result_valid, overflow
    );

endinterface

// File: rtl/pix_xy_tracker.sv
// x/y position of the pixel on the bus. x and y are the coordinates of the
// pixel presented this cycle: clear marks it as the frame origin (0,0),
// advance steps the stored position past it with line/frame wrap, and eof
// flags the last active pixel of the frame.
module pix_xy_tracker
    import pixcount_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   eof
);

    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

    coord_t x_q;
    coord_t y_q;

    // Current-pixel coordinates; the origin pixel overrides the stored position.
    always_comb begin
        x   = clear ? '0 : x_q;
        y   = clear ? '0 : y_q;
        eof = (x == X_LAST) && (y == Y_LAST);
    end

    // Position register: step past the current pixel, wrapping at line end.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x_q <= '0;
                y_q <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x_q <= x + 1'b1;
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/pixcount_ctrl.sv
// Frame-synchronous windowed counter of pixels with R, G and B all non-zero.
// Arms on start, aligns to the next frame_start, counts one frame and hands
// the total out through result_valid/result_ack.
// Optional build macro PIXCNT_CONTINUOUS_EN: re-arm after every frame,
// result_valid is a one-cycle pulse and result_ack is ignored.
module pixcount_ctrl
    import pixcount_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    pixcount_if.slave bus
);

    state_t           state_q, state_d;
    window_t          win_q;
    logic             latch_win;

    logic [CNT_W-1:0] count_q, count_d, acc_cnt;
    logic             ovf_q, ovf_d, acc_ovf;
    logic [CNT_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    coord_t           x, y;
    logic             origin, advance, eof, qual;

    // The first pixel of a frame is always the origin, both when arming and
    // when resynchronising mid-count.
    assign origin  = bus.frame_start && bus.pix_valid;
    assign advance = bus.pix_valid &&
                     ((state_q == ST_COUNT) || ((state_q == ST_ARM) && bus.frame_start));

    pix_xy_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (origin),
        .advance (advance),
        .x       (x),
        .y       (y),
        .eof     (eof)
    );

    assign qual = bus.pix_valid &&
                  in_range(x, win_q.x0, win_q.x1) &&
                  in_range(y, win_q.y0, win_q.y1) &&
                  (|bus.r) && (|bus.g) && (|bus.b);

    // Next state, saturating accumulate and result/handshake updates.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        latch_win  = 1'b0;
`ifdef PIXCNT_CONTINUOUS_EN
        result_valid_d = 1'b0;
`else
        result_valid_d = result_valid_q;
`endif

        // Saturating add of this pixel; a qualifying pixel lost to
        // saturation marks the frame as overflowed.
        acc_cnt = count_q;
        acc_ovf = ovf_q;
        if (qual) begin
            if (&count_q) begin
                acc_ovf = 1'b1;
            end else begin
                acc_cnt = count_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_ARM;
                    latch_win = 1'b1;
                end
            end
            ST_ARM: begin
                if (origin) begin
                    state_d = ST_COUNT;
                    count_d = CNT_W'(qual);
                    ovf_d   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (origin) begin
                    // Resync: the truncated frame is discarded.
                    count_d = CNT_W'(qual);
                    ovf_d   = 1'b0;
                end else if (bus.pix_valid) begin
                    count_d = acc_cnt;
                    ovf_d   = acc_ovf;
                    if (eof) begin
                        result_d       = acc_cnt;
                        overflow_d     = acc_ovf;
                        result_valid_d = 1'b1;
`ifdef PIXCNT_CONTINUOUS_EN
                        state_d = ST_ARM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
`ifdef PIXCNT_CONTINUOUS_EN
                state_d = ST_ARM;
`else
                if (bus.result_ack) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b0;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Count, result and status registers; all outputs come from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            ovf_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
        end
    end

    // Window bounds captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (latch_win) begin
            win_q <= '{x0: bus.win_x0, x1: bus.win_x1, y0: bus.win_y0, y1: bus.win_y1};
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_pixcount_ctrl.sv
// Directed bench for pixcount_ctrl on an 8x4 frame. A 32-bit and a 4-bit
// counter instance see identical stimulus; the 4-bit one covers saturation.
module tb_pixcount_ctrl;
    import pixcount_pkg::*;

    localparam int H = 8;
    localparam int V = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pixcount_if #(.CNT_W(32)) bus ();
    pixcount_if #(.CNT_W(4))  bus_s ();

    assign bus_s.start       = bus.start;
    assign bus_s.frame_start = bus.frame_start;
    assign bus_s.pix_valid   = bus.pix_valid;
    assign bus_s.r           = bus.r;
    assign bus_s.g           = bus.g;
    assign bus_s.b           = bus.b;
    assign bus_s.win_x0      = bus.win_x0;
    assign bus_s.win_x1      = bus.win_x1;
    assign bus_s.win_y0      = bus.win_y0;
    assign bus_s.win_y1      = bus.win_y1;
    assign bus_s.result_ack  = bus.result_ack;

    pixcount_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pixcount_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pix_valid   = 1'b0;
            bus.frame_start = 1'b0;
            bus.start       = 1'b0;
            bus.result_ack  = 1'b0;
        end
    endtask

    task automatic set_window(input int x0, input int x1, input int y0, input int y1);
        bus.win_x0 = coord_t'(x0);
        bus.win_x1 = coord_t'(x1);
        bus.win_y0 = coord_t'(y0);
        bus.win_y1 = coord_t'(y1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic ack_result();
        @(negedge clk);
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
    endtask

    // kind 0: all pixels r=g=b=1; kind 1: same but (0,0) r=0 and (3,2) g=0.
    // gaps inserts a pix_valid=0 cycle carrying bright colour every third pixel.
    task automatic drive_frame(input int kind, input int n_pix, input bit gaps);
        for (int i = 0; i < n_pix; i++) begin
            int px;
            int py;
            px = i % H;
            py = i / H;
            if (gaps && (i % 3 == 2)) begin
                @(negedge clk);
                bus.pix_valid   = 1'b0;
                bus.frame_start = 1'b0;
                bus.r = 8'hff; bus.g = 8'hff; bus.b = 8'hff;
            end
            @(negedge clk);
            bus.pix_valid   = 1'b1;
            bus.frame_start = (i == 0);
            bus.r = 8'd1; bus.g = 8'd1; bus.b = 8'd1;
            if (kind == 1 && px == 0 && py == 0) bus.r = 8'd0;
            if (kind == 1 && px == 3 && py == 2) bus.g = 8'd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        bus.r = 8'd0; bus.g = 8'd0; bus.b = 8'd0;
        bus.result_ack = 1'b0;
        set_window(0, 7, 0, 3);

        #2 rst_n = 1'b0;
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset valid", 32'(bus.result_valid), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

`ifndef PIXCNT_CONTINUOUS_EN
        // White frame, full window, with freeze gaps.
        pulse_start();
        check("busy after start", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.pix_valid = 1'b1; bus.frame_start = 1'b0;
        bus.r = 8'd1; bus.g = 8'd1; bus.b = 8'd1;
        idle(2);
        check("arm no frame_start valid", 32'(bus.result_valid), 32'd0);
        check("arm busy", 32'(bus.busy), 32'd1);
        drive_frame(0, H * V, 1'b1);
        idle(1);
        check("white valid", 32'(bus.result_valid), 32'd1);
        check("white result", bus.result, 32'd32);
        check("white overflow", 32'(bus.overflow), 32'd0);
        check("sat result", 32'(bus_s.result), 32'd15);
        check("sat overflow", 32'(bus_s.overflow), 32'd1);
        idle(3);
        check("valid held", 32'(bus.result_valid), 32'd1);
        check("busy in done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.result_ack = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        bus.start      = 1'b0;
        check("valid after ack", 32'(bus.result_valid), 32'd0);
        check("start with ack ignored", 32'(bus.busy), 32'd0);
        idle(2);
        check("start with ack ignored late", 32'(bus.busy), 32'd0);
        check("result holds", bus.result, 32'd32);

        // Two dark pixels.
        pulse_start();
        drive_frame(1, H * V, 1'b0);
        idle(1);
        check("dark px result", bus.result, 32'd30);
        check("dark px valid", 32'(bus.result_valid), 32'd1);
        ack_result();
        check("dark px ack", 32'(bus.result_valid), 32'd0);

        // Sub-window; a start while armed must not relatch bounds.
        set_window(2, 5, 1, 2);
        pulse_start();
        set_window(0, 7, 0, 3);
        pulse_start();
        drive_frame(0, H * V, 1'b0);
        idle(1);
        check("window result", bus.result, 32'd8);
        ack_result();

        // Inverted window is empty.
        set_window(5, 2, 0, 3);
        pulse_start();
        drive_frame(0, H * V, 1'b0);
        idle(1);
        check("empty window valid", 32'(bus.result_valid), 32'd1);
        check("empty window result", bus.result, 32'd0);
        check("empty window overflow", 32'(bus.overflow), 32'd0);
        check("empty window sat overflow", 32'(bus_s.overflow), 32'd0);
        ack_result();

        // Resync at (4,1): truncated white frame, then a full dark-pixel frame.
        set_window(0, 7, 0, 3);
        pulse_start();
        drive_frame(0, 12, 1'b0);
        idle(1);
        check("truncated no valid", 32'(bus.result_valid), 32'd0);
        check("truncated busy", 32'(bus.busy), 32'd1);
        drive_frame(1, H * V, 1'b0);
        idle(1);
        check("resync valid", 32'(bus.result_valid), 32'd1);
        check("resync result", bus.result, 32'd30);
        ack_result();

        // Reset in the middle of a counted frame.
        pulse_start();
        drive_frame(0, 10, 1'b0);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset result", bus.result, 32'd0);
        check("midreset valid", 32'(bus.result_valid), 32'd0);
        check("midreset overflow", 32'(bus.overflow), 32'd0);
        check("midreset sat result", 32'(bus_s.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame(0, H * V, 1'b0);
        idle(1);
        check("idle after reset no valid", 32'(bus.result_valid), 32'd0);
        check("idle after reset busy", 32'(bus.busy), 32'd0);
        pulse_start();
        drive_frame(0, H * V, 1'b0);
        idle(1);
        check("post reset result", bus.result, 32'd32);
        ack_result();
`else
        // Continuous: one start, three frames, no ack.
        pulse_start();
        check("busy after start", 32'(bus.busy), 32'd1);
        for (int f = 0; f < 3; f++) begin
            drive_frame(0, H * V, f == 1);
            idle(1);
            check($sformatf("cont valid f%0d", f), 32'(bus.result_valid), 32'd1);
            check($sformatf("cont result f%0d", f), bus.result, 32'd32);
            check($sformatf("cont sat overflow f%0d", f), 32'(bus_s.overflow), 32'd1);
            idle(1);
            check($sformatf("cont pulse end f%0d", f), 32'(bus.result_valid), 32'd0);
            check($sformatf("cont busy f%0d", f), 32'(bus.busy), 32'd1);
            idle(2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
